// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB master driver.
// The command struct is sized from the package defaults, so non-default driver widths must not exceed them.
package apb_master_pkg;

    function automatic int slv_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int APB_ADDR_W       = 32;
    localparam int APB_DATA_W       = 32;
    localparam int APB_STRB_W       = APB_DATA_W / 8;
    localparam int APB_NO_OF_SLAVES = 1;
    localparam int APB_WAIT_TIMEOUT = 16;
    localparam int APB_SLV_W        = slv_width(APB_NO_OF_SLAVES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic [2:0]            prot;
        logic [APB_SLV_W-1:0]  slave;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_monitor.sv
// Passive APB observer: reports each completed bus transfer one cycle later,
// with its wait-state count and a wrapping transfer counter.
module apb_master_monitor #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NO_OF_SLAVES = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [NO_OF_SLAVES-1:0] i_psel,
    input  logic                    i_penable,
    input  logic                    i_pwrite,
    input  logic [ADDR_WIDTH-1:0]   i_paddr,
    input  logic [DATA_WIDTH-1:0]   i_pwdata,
    input  logic [DATA_WIDTH-1:0]   i_prdata,
    input  logic                    i_pready,
    input  logic                    i_pslverr,
    output logic                    o_valid,
    output logic                    o_write,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_slverr,
    output logic [7:0]              o_waits,
    output logic [15:0]             o_count
);

    logic                  w_access, w_done;
    logic                  r_valid, r_write, r_slverr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [7:0]            r_waits, r_wait_cnt;
    logic [15:0]           r_count;

    assign w_access = (|i_psel) & i_penable;
    assign w_done   = w_access & i_pready;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_valid    <= 1'b0;
            r_write    <= 1'b0;
            r_slverr   <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_waits    <= '0;
            r_count    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_write    <= i_pwrite;
                r_addr     <= i_paddr;
                r_data     <= i_pwrite ? i_pwdata : i_prdata;
                r_slverr   <= i_pslverr;
                r_waits    <= r_wait_cnt;
                r_count    <= r_count + 16'd1;
                r_wait_cnt <= '0;
            end else if (w_access) begin
                r_wait_cnt <= (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
            end else begin
                // aborted transfers (timeout, reset) leave no stale count behind
                r_wait_cnt <= '0;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_write  = r_write;
    assign o_addr   = r_addr;
    assign o_data   = r_data;
    assign o_slverr = r_slverr;
    assign o_waits  = r_waits;
    assign o_count  = r_count;

endmodule

// File: rtl/apb_master_driver.sv
// APB master: turns a valid/ready command stream into APB SETUP/ACCESS transfers with timeout.
// Define APB_MASTER_MONITOR_EN to add the apb_master_monitor and its mon_* ports.
module apb_master_driver
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH   = APB_ADDR_W,
    parameter int DATA_WIDTH   = APB_DATA_W,
    parameter int NO_OF_SLAVES = APB_NO_OF_SLAVES,
    parameter int WAIT_TIMEOUT = APB_WAIT_TIMEOUT
) (
    input  logic                                pclk,
    input  logic                                presetn,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [ADDR_WIDTH-1:0]               cmd_addr,
    input  logic [DATA_WIDTH-1:0]               cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]             cmd_strb,
    input  logic [2:0]                          cmd_prot,
    input  logic [slv_width(NO_OF_SLAVES)-1:0]  cmd_slave,
    output logic                                rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_slverr,
    output logic                                rsp_timeout,
    output logic [NO_OF_SLAVES-1:0]             psel,
    output logic                                penable,
    output logic                                pwrite,
    output logic [ADDR_WIDTH-1:0]               paddr,
    output logic [DATA_WIDTH-1:0]               pwdata,
    output logic [DATA_WIDTH/8-1:0]             pstrb,
    output logic [2:0]                          pprot,
    input  logic                                pready,
    input  logic [DATA_WIDTH-1:0]               prdata,
    input  logic                                pslverr
`ifdef APB_MASTER_MONITOR_EN
    ,
    output logic                                mon_valid,
    output logic                                mon_write,
    output logic [ADDR_WIDTH-1:0]               mon_addr,
    output logic [DATA_WIDTH-1:0]               mon_data,
    output logic                                mon_slverr,
    output logic [7:0]                          mon_waits,
    output logic [15:0]                         mon_count
`endif
);

    localparam int SW    = slv_width(NO_OF_SLAVES);
    localparam int STRBW = DATA_WIDTH / 8;
    localparam int WW    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    apb_state_e       r_state;
    apb_cmd_t         r_cmd, w_cmd_nxt;
    logic             r_ready_en, r_bad_pend;
    logic [WW-1:0]    r_wait;
    logic             r_rsp_valid, r_rsp_slverr, r_rsp_timeout;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic             w_in_idle, w_in_access, w_done, w_timeout, w_hs, w_bad;

    assign w_in_idle   = (r_state == ST_IDLE);
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_done      = w_in_access & pready;
    assign w_timeout   = (WAIT_TIMEOUT > 0) && w_in_access && !pready
                         && (r_wait == WW'(WAIT_TIMEOUT - 1));
    // an invalid-slave command taken at ACCESS completion owes its response one cycle late; hold off intake meanwhile
    assign cmd_ready   = r_ready_en & ((w_in_idle & ~r_bad_pend) | w_done);
    assign w_hs        = cmd_valid & cmd_ready;
    assign w_bad       = 32'(cmd_slave) >= 32'(NO_OF_SLAVES);

    always_comb begin
        w_cmd_nxt       = '0;
        w_cmd_nxt.write = cmd_write;
        w_cmd_nxt.addr  = APB_ADDR_W'(cmd_addr);
        w_cmd_nxt.wdata = cmd_write ? APB_DATA_W'(cmd_wdata) : '0;
        w_cmd_nxt.strb  = cmd_write ? APB_STRB_W'(cmd_strb) : '0;
        w_cmd_nxt.prot  = cmd_prot;
        w_cmd_nxt.slave = APB_SLV_W'(cmd_slave);
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_ready_en    <= 1'b0;
            r_bad_pend    <= 1'b0;
            r_wait        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
        end else begin
            r_ready_en    <= 1'b1;
            r_bad_pend    <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (r_bad_pend) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= 1'b1;
                    end else if (w_hs) begin
                        r_cmd <= w_cmd_nxt;
                        if (w_bad) begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_slverr <= 1'b1;
                        end else begin
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    r_wait  <= '0;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_rdata  <= r_cmd.write ? '0 : prdata;
                        r_rsp_slverr <= pslverr;
                        if (w_hs) begin
                            r_cmd <= w_cmd_nxt;
                            if (w_bad) begin
                                r_bad_pend <= 1'b1;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_state <= ST_SETUP;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NO_OF_SLAVES; g++) begin : g_psel
        assign psel[g] = !w_in_idle && (r_cmd.slave == APB_SLV_W'(g));
    end

    assign penable     = w_in_access;
    assign pwrite      = r_cmd.write;
    assign paddr       = ADDR_WIDTH'(r_cmd.addr);
    assign pwdata      = DATA_WIDTH'(r_cmd.wdata);
    assign pstrb       = STRBW'(r_cmd.strb);
    assign pprot       = r_cmd.prot;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;

`ifdef APB_MASTER_MONITOR_EN
    apb_master_monitor #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .NO_OF_SLAVES (NO_OF_SLAVES)
    ) u_mon (
        .i_clk     (pclk),
        .i_rstn    (presetn),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_paddr   (paddr),
        .i_pwdata  (pwdata),
        .i_prdata  (prdata),
        .i_pready  (pready),
        .i_pslverr (pslverr),
        .o_valid   (mon_valid),
        .o_write   (mon_write),
        .o_addr    (mon_addr),
        .o_data    (mon_data),
        .o_slverr  (mon_slverr),
        .o_waits   (mon_waits),
        .o_count   (mon_count)
    );
`endif

endmodule

// File: tb/tb_apb_master_driver.sv
// Directed bench for apb_master_driver (WAIT_TIMEOUT=4, one slave); mon_* checks when APB_MASTER_MONITOR_EN is set.
module tb_apb_master_driver;

    logic        pclk, presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic [0:0]  cmd_slave;
    logic        rsp_valid, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [0:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
    logic [31:0] prdata;
`ifdef APB_MASTER_MONITOR_EN
    logic        mon_valid, mon_write, mon_slverr;
    logic [31:0] mon_addr, mon_data;
    logic [7:0]  mon_waits;
    logic [15:0] mon_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    apb_master_driver #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NO_OF_SLAVES(1), .WAIT_TIMEOUT(4)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_slave(cmd_slave),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
`ifdef APB_MASTER_MONITOR_EN
        ,
        .mon_valid(mon_valid), .mon_write(mon_write), .mon_addr(mon_addr),
        .mon_data(mon_data), .mon_slverr(mon_slverr), .mon_waits(mon_waits),
        .mon_count(mon_count)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [0:0] slv);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        cmd_strb = s; cmd_prot = 3'd2; cmd_slave = slv;
    endtask

    task automatic bus(input logic rdy, input logic [31:0] rd, input logic err);
        pready = rdy; prdata = rd; pslverr = err;
    endtask

    initial begin
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; cmd_slave = '0;
        bus(1'b0, 32'h0, 1'b0);
        tick(); tick(); settle();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_psel",  {31'd0, psel}, 32'd0);
        chk("rst_rsp",   {31'd0, rsp_valid}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        presetn = 1'b1;
        tick(); settle();
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

        // write 0x10, zero wait states
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0); bus(1'b1, 32'h0, 1'b0); settle();
        chk("w_hs_ready", {31'd0, cmd_ready}, 32'd1);
        tick(); cmd_valid = 1'b0; settle();
        chk("w_setup_psel", {31'd0, psel, penable}, 32'b10);
        chk("w_paddr", paddr, 32'h10);
        chk("w_pwdata", pwdata, 32'hDEADBEEF);
        chk("w_pstrb", {28'd0, pstrb}, 32'hF);
        chk("w_pprot", {29'd0, pprot}, 32'd2);
        tick(); settle();
        chk("w_access", {30'd0, psel, penable}, 32'b11);
        chk("w_rsp_early", {31'd0, rsp_valid}, 32'd0);
        tick(); bus(1'b0, 32'h0, 1'b0); settle();
        chk("w_rsp", {29'd0, rsp_valid, rsp_slverr, rsp_timeout}, 32'b100);
        chk("w_rdata", rsp_rdata, 32'h0);
        chk("w_idle_psel", {31'd0, psel}, 32'd0);
`ifdef APB_MASTER_MONITOR_EN
        chk("w_mon", {30'd0, mon_valid, mon_write}, 32'b11);
        chk("w_mon_data", mon_data, 32'hDEADBEEF);
        chk("w_mon_cnt", {16'd0, mon_count}, 32'd1);
`endif
        tick(); settle();
        chk("w_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

        // read 0x20 with 2 wait states; junk bus data during waits must be ignored
        send(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b0); settle();
        tick(); cmd_valid = 1'b0; settle();
        chk("r_setup_strb", {28'd0, pstrb}, 32'd0);
        chk("r_setup_wdata", pwdata, 32'd0);
        tick(); bus(1'b0, 32'hBAD0BAD0, 1'b1); settle();
        chk("r_wait1", {29'd0, psel, penable, pstrb != 4'd0}, 32'b110);
        tick(); settle();
        chk("r_wait2", {29'd0, psel, penable, rsp_valid}, 32'b110);
        tick(); bus(1'b1, 32'h12345678, 1'b0); settle();
        chk("r_done_strb", {28'd0, pstrb}, 32'd0);
        tick(); bus(1'b0, 32'h0, 1'b0); settle();
        chk("r_rsp", {29'd0, rsp_valid, rsp_slverr, rsp_timeout}, 32'b100);
        chk("r_rdata", rsp_rdata, 32'h12345678);
`ifdef APB_MASTER_MONITOR_EN
        chk("r_mon_waits", {24'd0, mon_waits}, 32'd2);
        chk("r_mon_data", mon_data, 32'h12345678);
`endif
        tick();

        // back-to-back: second SETUP right after first ACCESS completes
        send(1'b1, 32'h30, 32'hA5A5A5A5, 4'h3, 1'b0); settle();
        tick(); send(1'b0, 32'h40, 32'h0, 4'hF, 1'b0); settle();
        chk("b2b_setup_ready", {31'd0, cmd_ready}, 32'd0);
        tick(); bus(1'b1, 32'h0, 1'b0); settle();
        chk("b2b_access_ready", {31'd0, cmd_ready}, 32'd1);
        chk("b2b_paddr_a", paddr, 32'h30);
        tick(); cmd_valid = 1'b0; bus(1'b0, 32'h0, 1'b0); settle();
        chk("b2b_setup2", {30'd0, psel, penable}, 32'b10);
        chk("b2b_paddr_b", paddr, 32'h40);
        chk("b2b_rsp_a", {31'd0, rsp_valid}, 32'd1);
        tick(); bus(1'b1, 32'hCAFEF00D, 1'b0); settle();
        tick(); bus(1'b0, 32'h0, 1'b0); settle();
        chk("b2b_rsp_b", rsp_rdata, 32'hCAFEF00D);
`ifdef APB_MASTER_MONITOR_EN
        chk("b2b_mon_cnt", {16'd0, mon_count}, 32'd4);
`endif
        tick();

        // timeout after 4 wait cycles
        send(1'b0, 32'h50, 32'h0, 4'h0, 1'b0); settle();
        tick(); cmd_valid = 1'b0; settle();
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk("to_waiting", {30'd0, psel, penable}, 32'b11);
        end
        tick(); settle();
        chk("to_drop", {30'd0, psel, penable}, 32'b00);
        chk("to_rsp", {29'd0, rsp_valid, rsp_slverr, rsp_timeout}, 32'b111);
        chk("to_rdata", rsp_rdata, 32'h0);
`ifdef APB_MASTER_MONITOR_EN
        chk("to_mon_valid", {31'd0, mon_valid}, 32'd0);
`endif
        tick();

        // invalid slave index: immediate error, no bus activity
        send(1'b1, 32'h70, 32'h1, 4'hF, 1'b1); settle();
        tick(); cmd_valid = 1'b0; settle();
        chk("bad_psel", {31'd0, psel}, 32'd0);
        chk("bad_rsp", {29'd0, rsp_valid, rsp_slverr, rsp_timeout}, 32'b110);
        tick();

        // reset during ACCESS
        send(1'b1, 32'h80, 32'h11112222, 4'hF, 1'b0); settle();
        tick(); cmd_valid = 1'b0; settle();
        tick(); presetn = 1'b0; settle();
        chk("rst_mid_access", {30'd0, psel, penable}, 32'b11);
        tick(); settle();
        chk("rst_mid_bus", {29'd0, psel, penable, cmd_ready}, 32'b000);
        chk("rst_mid_paddr", paddr, 32'd0);
        presetn = 1'b1;
        tick(); settle();
        chk("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
`ifdef APB_MASTER_MONITOR_EN
        chk("rst_mon_cnt", {16'd0, mon_count}, 32'd0);
`endif
        chk("rst_rel_ready", {31'd0, cmd_ready}, 32'd1);

        // write answered with pslverr
        send(1'b1, 32'h60, 32'h0BADF00D, 4'hF, 1'b0); settle();
        tick(); cmd_valid = 1'b0; settle();
        tick(); bus(1'b1, 32'h0, 1'b1); settle();
        tick(); bus(1'b0, 32'h0, 1'b0); settle();
        chk("err_rsp", {29'd0, rsp_valid, rsp_slverr, rsp_timeout}, 32'b110);
`ifdef APB_MASTER_MONITOR_EN
        chk("err_mon", {30'd0, mon_valid, mon_slverr}, 32'b11);
        chk("err_mon_cnt", {16'd0, mon_count}, 32'd1);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master_driver.md
APB_MASTER_DRIVER -- requirements
Module: apb_master_driver

Interface
REQ-001 The block SHALL have parameters ADDR_WIDTH, 32, APB address width; DATA_WIDTH, 32, APB data width (8/16/32); NO_OF_SLAVES, 1, psel width; WAIT_TIMEOUT, 16, max wait states before abort (0 = disabled).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows: pclk input 1, APB clock; presetn input 1, synchronous active-low reset.
REQ-003 cmd_valid input 1, command offered; cmd_ready output 1, command accepted when both high.
REQ-004 cmd_write input 1, 1=write; cmd_addr input ADDR_WIDTH; cmd_wdata input DATA_WIDTH; cmd_strb input DATA_WIDTH/8; cmd_prot input 3; cmd_slave input $clog2(NO_OF_SLAVES) (min 1 bit), slave index.
REQ-005 rsp_valid output 1, one-cycle completion pulse; rsp_rdata output DATA_WIDTH; rsp_slverr output 1; rsp_timeout output 1.
REQ-006 psel output NO_OF_SLAVES one-hot; penable output 1; pwrite output 1; paddr output ADDR_WIDTH; pwdata output DATA_WIDTH; pstrb output DATA_WIDTH/8; pprot output 3.
REQ-007 pready input 1; prdata input DATA_WIDTH; pslverr input 1.

Function
REQ-008 The FSM SHALL have states IDLE, SETUP, ACCESS; IDLE->SETUP on cmd handshake; SETUP->ACCESS unconditionally; ACCESS holds while pready=0.
REQ-009 cmd_ready SHALL be 1 in IDLE and in ACCESS when pready=1, and 0 otherwise; ACCESS with pready=1 SHALL go to SETUP on a handshake and to IDLE without one (back-to-back transfers, no idle gap).
REQ-010 On handshake the block SHALL register all cmd_* fields; paddr/pwrite/pwdata/pstrb/pprot SHALL be driven from the registers in SETUP and held stable through ACCESS.
REQ-011 In SETUP, psel[cmd_slave]=1 and penable=0; in ACCESS, psel held and penable=1; in IDLE, psel=0 and penable=0.
REQ-012 A cmd_slave value >= NO_OF_SLAVES SHALL complete immediately without APB activity: no psel, rsp_valid 1 cycle after handshake, rsp_slverr=1.
REQ-013 For reads, pstrb SHALL be forced to 0 and pwdata SHALL be 0.
REQ-014 A transfer SHALL complete when ACCESS has pready=1; the next cycle, rsp_valid=1 for exactly one cycle, with rsp_rdata=prdata (0 for writes) and rsp_slverr=pslverr, both sampled at completion.
REQ-015 Minimum latency SHALL be: handshake at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3; each wait state adds one cycle.
REQ-016 A consecutive-wait counter SHALL run in ACCESS; when WAIT_TIMEOUT>0 and the counter reaches WAIT_TIMEOUT with pready=0, the FSM SHALL go to IDLE (psel/penable dropped) and pulse rsp_valid with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
REQ-017 pslverr and prdata SHALL be ignored outside completing ACCESS cycles.

Reset
REQ-018 With presetn=0 at a pclk edge, the block SHALL enter IDLE and set all outputs to 0 (cmd_ready becomes 1 after release), clear the wait counter and discard any in-flight transfer with no rsp_valid.
REQ-019 Reset asserted mid-transfer SHALL deassert psel/penable at that edge.

Configuration
REQ-020 With the macro APB_MASTER_MONITOR_EN defined, the block SHALL include the monitor and its outputs: mon_valid output 1, mon_write output 1, mon_addr output ADDR_WIDTH, mon_data output DATA_WIDTH (pwdata for writes, prdata for reads), mon_slverr output 1, mon_waits output 8 (saturating wait-state count of that transfer), mon_count output 16 (wrapping completed-transfer count).
REQ-021 mon_valid SHALL pulse one cycle after each bus completion (psel&penable&pready), sampling the bus pins; timeouts and invalid-slave commands SHALL NOT be counted; all mon_* outputs SHALL reset to 0.
REQ-022 Without APB_MASTER_MONITOR_EN, the mon_* ports and the monitor logic SHALL be absent and driver behaviour SHALL be identical.

Structure
REQ-023 Package apb_master_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS), default parameter constants and a command struct (write, addr, wdata, strb, prot, slave).
REQ-024 The monitor SHALL be a sub-module, apb_master_monitor, that observes only APB pins and is instantiated under APB_MASTER_MONITOR_EN.

Verification
REQ-025 Write to 0x10 with data 0xDEADBEEF, strb 0xF and pready tied 1: psel at N+1, penable at N+2, rsp_valid at N+3 with slverr=0.
REQ-026 Read from 0x20 with 2 wait states and prdata 0x12345678 at completion: rsp_valid at N+5 with rsp_rdata=0x12345678 and pstrb=0 throughout.
REQ-027 Two commands held valid back-to-back: second SETUP in the cycle after the first ACCESS completes, with no IDLE cycle between.
REQ-028 WAIT_TIMEOUT=4 with pready stuck 0: after 4 ACCESS wait cycles psel drops and rsp_valid fires with slverr=1 and timeout=1.
REQ-029 presetn=0 during ACCESS: next cycle all outputs are 0 and no rsp_valid is produced; a write with pslverr=1 gives rsp_slverr=1, and mon_count increments by 1 when APB_MASTER_MONITOR_EN is defined.
